conv_mac_engine: RTL

Downstream of the image fetch unit. Consumes each sliding K×K pixel window and its window_valid strobe, and multiplies the window element-wise against a locally stored kernel. It adds a bias, applies a fixed-point shift, optional ReLU and saturation, then writes one result per window into the output feature-map BRAM. A 4-stage pipeline sustains one window per cycle.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv_mac_pipe.sv | 93 +++++++++
 rtl/conv_mac_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and result saturation for the convolution MAC engine.
package conv_pkg;

   localparam int MAX_KERNEL_SIZE = 5;
   localparam int BIAS_ADDR       = 25;
   localparam int PIPE_LAT        = 4;
   localparam int SAT_W           = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Clamp a wide signed value into the signed range of a dw-bit result.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
      lo = -hi - SAT_W'(1);
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// Four-stage MAC datapath: products, row sums, bias add, then shift/ReLU/saturate.
module conv_mac_pipe
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 0,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+5
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  flush,
   input  logic                                                  in_valid,
   input  logic [DATA_WIDTH*MAX_KERNEL_SIZE*MAX_KERNEL_SIZE-1:0] window,
   input  logic [DATA_WIDTH*MAX_KERNEL_SIZE*MAX_KERNEL_SIZE-1:0] weights,
   input  logic [DATA_WIDTH-1:0]                                 bias,
   input  logic [2:0]                                            ker_size,
   input  logic                                                  relu_en,
   output logic                                                  out_valid,
   output logic [DATA_WIDTH-1:0]                                 result
);

   localparam int MK = MAX_KERNEL_SIZE;
   localparam int NE = MK*MK;
   localparam int PW = 2*DATA_WIDTH;

   logic signed [PW-1:0]        prod_c  [NE];
   logic signed [PW-1:0]        prod_q  [NE];
   logic signed [ACC_WIDTH-1:0] row_c   [MK];
   logic signed [ACC_WIDTH-1:0] row_q   [MK];
   logic signed [ACC_WIDTH-1:0] total_c;
   logic signed [ACC_WIDTH-1:0] total_q;
   logic signed [SAT_W-1:0]     shifted_c;
   logic [DATA_WIDTH-1:0]       result_c;
   logic                        v1_q, v2_q, v3_q;
   logic                        ks_ok;

   assign ks_ok = (ker_size == 3'd2) || (ker_size == 3'd3) || (ker_size == 3'd5);

   // Element i is window[row i/MK][col i%MK]; entries outside the active kernel contribute 0.
   always_comb begin
      for (int i = 0; i < NE; i++) begin
         prod_c[i] = '0;
         if (ks_ok && ((i / MK) < int'(ker_size)) && ((i % MK) < int'(ker_size)))
            prod_c[i] = PW'(signed'(window[i*DATA_WIDTH +: DATA_WIDTH])) *
                        PW'(signed'(weights[i*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   always_comb begin
      for (int r = 0; r < MK; r++) begin
         row_c[r] = '0;
         for (int c = 0; c < MK; c++)
            row_c[r] = row_c[r] + ACC_WIDTH'(prod_q[r*MK+c]);
      end
   end

   always_comb begin
      total_c = ACC_WIDTH'(signed'(bias));
      for (int r = 0; r < MK; r++)
         total_c = total_c + row_q[r];
   end

   always_comb begin
      shifted_c = SAT_W'(total_q) >>> FRAC_BITS;
      if (relu_en && (shifted_c < 0))
         shifted_c = '0;
      result_c = DATA_WIDTH'(saturate(shifted_c, DATA_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         v1_q      <= in_valid && !flush;
         v2_q      <= v1_q && !flush;
         v3_q      <= v2_q && !flush;
         out_valid <= v3_q && !flush;
         if (v3_q)
            result <= result_c;
      end
   end

   always_ff @(posedge clk) begin
      prod_q  <= prod_c;
      row_q   <= row_c;
      total_q <= total_c;
   end

endmodule

// File: rtl/conv_mac_engine.sv
// Convolution MAC engine: frame FSM, kernel/bias register file and output address generation
// around the conv_mac_pipe datapath. pe_windows element [row][col] sits at index row*5+col.
module conv_mac_engine
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int FRAC_BITS  = 0,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+5
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  start,
   input  logic [ADDR_WIDTH-1:0]                                 out_base_addr,
   input  logic [2:0]                                            ker_size,
   input  logic                                                  relu_en,
   input  logic                                                  wt_wr_en,
   input  logic [4:0]                                            wt_wr_addr,
   input  logic [DATA_WIDTH-1:0]                                 wt_wr_data,
   input  logic [DATA_WIDTH*MAX_KERNEL_SIZE*MAX_KERNEL_SIZE-1:0] pe_windows,
   input  logic                                                  window_valid,
   input  logic                                                  frame_done,
   output logic                                                  out_bram_we,
   output logic [ADDR_WIDTH-1:0]                                 out_bram_addr,
   output logic [DATA_WIDTH-1:0]                                 out_bram_dout,
   output logic                                                  busy,
   output logic                                                  conv_done,
   output logic [ADDR_WIDTH-1:0]                                 result_count
);

   localparam int NE = MAX_KERNEL_SIZE*MAX_KERNEL_SIZE;

   state_t                  state_q;
   logic [2:0]              drain_cnt_q;
   logic                    relu_q;
   logic [DATA_WIDTH-1:0]   wt_q [NE];
   logic [DATA_WIDTH-1:0]   bias_q;
   logic [DATA_WIDTH*NE-1:0] wt_flat;
   logic                    wt_open;
   logic                    frame_init;
   logic                    restart;
   logic                    pipe_in_valid;

   assign busy          = (state_q == RUN) || (state_q == DRAIN);
   assign conv_done     = (state_q == DONE);
   assign wt_open       = (state_q == IDLE) || (state_q == DONE);
   assign frame_init    = start && ((state_q == IDLE) || (state_q == RUN));
   assign restart       = start && (state_q == RUN);
   assign pipe_in_valid = window_valid && (state_q == RUN) && !start;

   always_comb begin
      wt_flat = '0;
      for (int i = 0; i < NE; i++)
         wt_flat[i*DATA_WIDTH +: DATA_WIDTH] = wt_q[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NE; i++)
            wt_q[i] <= '0;
         bias_q <= '0;
      end else if (wt_wr_en && wt_open) begin
         if (wt_wr_addr < 5'(BIAS_ADDR))
            wt_q[wt_wr_addr] <= wt_wr_data;
         else if (wt_wr_addr == 5'(BIAS_ADDR))
            bias_q <= wt_wr_data;
      end
   end

   // A frame start (or restart) overrides the post-write address/count bump in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         drain_cnt_q   <= '0;
         relu_q        <= 1'b0;
         out_bram_addr <= '0;
         result_count  <= '0;
      end else begin
         if (out_bram_we) begin
            out_bram_addr <= out_bram_addr + ADDR_WIDTH'(1);
            result_count  <= result_count + ADDR_WIDTH'(1);
         end
         if (frame_init) begin
            out_bram_addr <= out_base_addr;
            result_count  <= '0;
            relu_q        <= relu_en;
         end
         case (state_q)
            IDLE:  if (start) state_q <= RUN;
            RUN: begin
               if (!start && frame_done) begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= 3'(PIPE_LAT);
               end
            end
            DRAIN: begin
               drain_cnt_q <= drain_cnt_q - 3'd1;
               if (drain_cnt_q == 3'd1)
                  state_q <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   conv_mac_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (restart),
      .in_valid  (pipe_in_valid),
      .window    (pe_windows),
      .weights   (wt_flat),
      .bias      (bias_q),
      .ker_size  (ker_size),
      .relu_en   (relu_q),
      .out_valid (out_bram_we),
      .result    (out_bram_dout)
   );

endmodule
